// File: rtl/arbitro_ula_if.sv
// arbitro_ula_if: request, response and ALU-side signals of arbitro_ula.
// Every *_valido/*_pronto pair transfers on the rising edge where both are high; valid never waits on ready.
interface arbitro_ula_if;
  logic        req0_valido;
  logic        req0_pronto;
  logic [3:0]  req0_comando;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valido;
  logic        req1_pronto;
  logic [3:0]  req1_comando;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        resp0_valido;
  logic        resp0_pronto;
  logic [31:0] resp0_resultado;
  logic        resp0_zero;
  logic        resp0_erro;
  logic        resp1_valido;
  logic        resp1_pronto;
  logic [31:0] resp1_resultado;
  logic        resp1_zero;
  logic        resp1_erro;
  logic [3:0]  ula_comando;
  logic [31:0] ula_entrada1;
  logic [31:0] ula_entrada2;
  logic [31:0] ula_saida;
  logic        ula_zeroflag;
  logic [1:0]  dbg_estado;

  // Arbiter side.
  modport slave (
    input  req0_valido, req0_comando, req0_a, req0_b,
    input  req1_valido, req1_comando, req1_a, req1_b,
    input  resp0_pronto, resp1_pronto, ula_saida, ula_zeroflag,
    output req0_pronto, req1_pronto,
    output resp0_valido, resp0_resultado, resp0_zero, resp0_erro,
    output resp1_valido, resp1_resultado, resp1_zero, resp1_erro,
    output ula_comando, ula_entrada1, ula_entrada2, dbg_estado
  );

  // Requesters plus ALU side.
  modport master (
    output req0_valido, req0_comando, req0_a, req0_b,
    output req1_valido, req1_comando, req1_a, req1_b,
    output resp0_pronto, resp1_pronto, ula_saida, ula_zeroflag,
    input  req0_pronto, req1_pronto,
    input  resp0_valido, resp0_resultado, resp0_zero, resp0_erro,
    input  resp1_valido, resp1_resultado, resp1_zero, resp1_erro,
    input  ula_comando, ula_entrada1, ula_entrada2, dbg_estado
  );
endinterface

// File: rtl/arbitro_ula.sv
// arbitro_ula: round-robin arbiter/sequencer sharing one 32-bit ALU between two requesters.
// Optional feature macro ARBITRO_ULA_DIVZERO_EN: answer divide/remainder by zero locally with erro=1.
module arbitro_ula #(
  parameter int ESPERA = 1
) (
  input logic          clock,
  input logic          reset,
  arbitro_ula_if.slave bus
);

`ifdef ARBITRO_ULA_DIVZERO_EN
  localparam bit DIVZERO_EN = 1'b1;
`else
  localparam bit DIVZERO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  estado_t     estado;
  estado_t     proximo;
  logic        ultimo;
  logic        id_q;
  logic        erro_pend;
  logic [3:0]  contador;
  logic [3:0]  cmd_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic        zero_q;
  logic        erro_q;
  logic        grant;
  logic        pronto0;
  logic        pronto1;
  logic        aceita;
  logic        div_zero;
  logic        consumido;
  logic [3:0]  sel_cmd;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  // Tie goes to the requester that was not served last.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valido && bus.req1_valido) grant = ~ultimo;
    else if (bus.req1_valido)               grant = 1'b1;
  end

  assign pronto0 = ~reset & (estado == OCIOSO) & ~grant & bus.req0_valido;
  assign pronto1 = ~reset & (estado == OCIOSO) &  grant & bus.req1_valido;
  assign aceita  = pronto0 | pronto1;

  assign sel_cmd = grant ? bus.req1_comando : bus.req0_comando;
  assign sel_a   = grant ? bus.req1_a       : bus.req0_a;
  assign sel_b   = grant ? bus.req1_b       : bus.req0_b;

  // Without the feature DIVZERO_EN is 0, so erro_pend and erro_q stay at 0.
  assign div_zero  = DIVZERO_EN && ((sel_cmd == 4'b0011) || (sel_cmd == 4'b0100)) && (sel_b == 32'd0);
  assign consumido = id_q ? bus.resp1_pronto : bus.resp0_pronto;

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:   if (aceita) proximo = EXECUTA;
      EXECUTA:  if (contador == 4'd0) proximo = RESPONDE;
      RESPONDE: if (consumido) proximo = OCIOSO;
      default:  proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // A rejected division waits one cycle with the ALU untouched, then answers from erro_pend.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ultimo    <= 1'b1;
      id_q      <= 1'b0;
      erro_pend <= 1'b0;
      contador  <= 4'd0;
      cmd_q     <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      res_q     <= 32'd0;
      zero_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else if (aceita) begin
      id_q      <= grant;
      ultimo    <= grant;
      erro_pend <= div_zero;
      contador  <= div_zero ? 4'd0 : 4'(ESPERA - 1);
      if (!div_zero) begin
        cmd_q <= sel_cmd;
        a_q   <= sel_a;
        b_q   <= sel_b;
      end
    end else if (estado == EXECUTA) begin
      if (contador == 4'd0) begin
        res_q  <= erro_pend ? 32'd0 : bus.ula_saida;
        zero_q <= ~erro_pend & bus.ula_zeroflag;
        erro_q <= erro_pend;
      end else begin
        contador <= contador - 4'd1;
      end
    end
  end

  assign bus.req0_pronto     = pronto0;
  assign bus.req1_pronto     = pronto1;
  assign bus.resp0_valido    = (estado == RESPONDE) & ~id_q;
  assign bus.resp1_valido    = (estado == RESPONDE) &  id_q;
  assign bus.resp0_resultado = res_q;
  assign bus.resp1_resultado = res_q;
  assign bus.resp0_zero      = zero_q;
  assign bus.resp1_zero      = zero_q;
  assign bus.resp0_erro      = erro_q;
  assign bus.resp1_erro      = erro_q;
  assign bus.ula_comando     = cmd_q;
  assign bus.ula_entrada1    = a_q;
  assign bus.ula_entrada2    = b_q;
  assign bus.dbg_estado      = estado;

endmodule

// File: tb/tb_arbitro_ula.sv
// tb_arbitro_ula: directed and random traffic on both requesters, with an ALU model and a scoreboard
// driven by a transaction-level arbitration/latency model.
module tb_arbitro_ula;
  localparam int ESPERA = 3;
`ifdef ARBITRO_ULA_DIVZERO_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  arbitro_ula_if bus ();

  arbitro_ula #(.ESPERA(ESPERA)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // ---------------- ALU model ----------------
  function automatic logic [32:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        z;
    z = 1'b0;
    case (c)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd4:    r = (b == 0) ? a : a % b;
      4'd5:    r = a & b;
      4'd6:    r = a | b;
      4'd7:    r = a ^ b;
      4'd8:    r = a << b[4:0];
      4'd9:    r = a >> b[4:0];
      4'd10:   begin r = {31'd0, $signed(a) < $signed(b)}; z = r[0]; end
      4'd11:   begin r = {31'd0, a == b}; z = (a == b); end
      4'd12:   r = $signed(a) >>> b[4:0];
      4'd13:   r = ~(a | b);
      4'd14:   r = b;
      default: r = a;
    endcase
    return {z, r};
  endfunction

  always_comb begin
    {bus.ula_zeroflag, bus.ula_saida} = alu_fn(bus.ula_comando, bus.ula_entrada1, bus.ula_entrada2);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [34:0] exp_q[$];
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  logic        m_id = 1'b0;
  logic        m_have = 1'b0;
  int          m_k = 0;
  int          m_lat = 0;
  logic [34:0] m_cur;
  logic [3:0]  m_cmd = 4'd0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  int          mw;
  logic [3:0]  mc;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [32:0] mzr;
  logic        mdz;
  logic [1:0]  mexp;
  logic [34:0] mact;

  always @(negedge clock) begin
    if (reset) begin
      chk("reset_ctrl", {bus.req1_pronto, bus.req0_pronto, bus.resp1_valido, bus.resp0_valido,
                         bus.resp1_zero, bus.resp0_zero, bus.resp1_erro, bus.resp0_erro,
                         bus.ula_comando, bus.dbg_estado}, 64'd0);
      chk("reset_res", {bus.resp1_resultado, bus.resp0_resultado}, 64'd0);
      chk("reset_ula", {bus.ula_entrada1, bus.ula_entrada2}, 64'd0);
      exp_q.delete();
      m_busy = 1'b0; m_last = 1'b1; m_have = 1'b0;
      m_cmd = 4'd0; m_a = 32'd0; m_b = 32'd0;
    end else begin
      chk("ula_regs", {bus.ula_comando, bus.ula_entrada1, bus.ula_entrada2}, {m_cmd, m_a, m_b});
      if (!m_busy) begin
        mw = -1;
        if (bus.req0_valido && bus.req1_valido) mw = m_last ? 0 : 1;
        else if (bus.req0_valido)               mw = 0;
        else if (bus.req1_valido)               mw = 1;
        mexp = (mw == 0) ? 2'b01 : (mw == 1) ? 2'b10 : 2'b00;
        chk("pronto", {bus.req1_pronto, bus.req0_pronto}, mexp);
        chk("resp_valido_ocioso", {bus.resp1_valido, bus.resp0_valido}, 64'd0);
        if (mw >= 0) begin
          mc  = (mw == 1) ? bus.req1_comando : bus.req0_comando;
          ma  = (mw == 1) ? bus.req1_a : bus.req0_a;
          mb  = (mw == 1) ? bus.req1_b : bus.req0_b;
          mdz = DZ && ((mc == 4'd3) || (mc == 4'd4)) && (mb == 32'd0);
          m_id = (mw == 1);
          if (mdz) begin
            exp_q.push_back({m_id, 1'b1, 1'b0, 32'd0});
            m_lat = 1;
          end else begin
            mzr = alu_fn(mc, ma, mb);
            exp_q.push_back({m_id, 1'b0, mzr});
            m_lat = ESPERA;
            m_cmd = mc; m_a = ma; m_b = mb;
          end
          m_busy = 1'b1; m_k = 0; m_last = m_id; m_have = 1'b0;
        end
      end else begin
        m_k++;
        chk("pronto_ocupado", {bus.req1_pronto, bus.req0_pronto}, 64'd0);
        mexp = (m_k > m_lat) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
        chk("resp_valido", {bus.resp1_valido, bus.resp0_valido}, mexp);
        if (m_k > m_lat && (m_id ? bus.resp1_valido : bus.resp0_valido)) begin
          if (!m_have) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL fila_vazia: response with no expected entry at %0t", $time);
            end else begin
              m_cur = exp_q.pop_front();
            end
            m_have = 1'b1;
          end
          mact = m_id ? {1'b1, bus.resp1_erro, bus.resp1_zero, bus.resp1_resultado}
                      : {1'b0, bus.resp0_erro, bus.resp0_zero, bus.resp0_resultado};
          chk("resposta", mact, m_cur);
          if (m_id ? bus.resp1_pronto : bus.resp0_pronto) m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input int n, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.req0_valido = 1'b1; bus.req0_comando = c; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valido = 1'b1; bus.req1_comando = c; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic withdraw(input int n);
    if (n == 0) bus.req0_valido = 1'b0;
    else        bus.req1_valido = 1'b0;
  endtask

  task automatic rand_present(input int n);
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    c = 4'($urandom_range(0, 15));
    a = $urandom;
    if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       b = 32'd0;
      1:       b = a;
      default: b = $urandom;
    endcase
    present(n, c, a, b);
  endtask

  task automatic wait_accept(input int n, input string name);
    int t;
    bit done;
    t = 0; done = 1'b0;
    while (!done && t < 64) begin
      @(negedge clock);
      done = (n == 0) ? (bus.req0_valido && bus.req0_pronto) : (bus.req1_valido && bus.req1_pronto);
      tick();
      t++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no accept within 64 cycles, got timeout expected accept", name);
    end
    withdraw(n);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (m_busy && t < 100) begin
      tick();
      t++;
    end
    if (m_busy) begin
      n_checks++; n_fail++;
      $display("FAIL %s: response not consumed within 100 cycles, got busy expected idle", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ord;
    int         grants;
    int         t;
    bit         acc0;
    bit         acc1;
    logic       first;

    bus.req0_valido = 1'b0; bus.req0_comando = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valido = 1'b0; bus.req1_comando = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.resp0_pronto = 1'b1; bus.resp1_pronto = 1'b1;
    reset = 1'b1;
    repeat (2) tick();
    present(0, 4'd0, 32'd1, 32'd1);
    present(1, 4'd0, 32'd2, 32'd2);
    repeat (2) tick();
    withdraw(0); withdraw(1);
    reset = 1'b0;
    tick();

    // Tie right after reset: continuous requests alternate starting with requester 0.
    present(0, 4'd1, 32'd9, 32'd4);
    present(1, 4'd1, 32'd3, 32'd3);
    ord = 4'd0; grants = 0; t = 0;
    while (grants < 4 && t < 200) begin
      @(negedge clock);
      if (bus.req0_valido && bus.req0_pronto) begin ord = {ord[2:0], 1'b0}; grants++; end
      if (bus.req1_valido && bus.req1_pronto) begin ord = {ord[2:0], 1'b1}; grants++; end
      tick();
      t++;
    end
    withdraw(0); withdraw(1);
    chk("ordem_empate", {28'd0, ord}, {28'd0, 4'b0101});
    wait_idle("empate");

    present(0, 4'd0, 32'd5, 32'd7);
    wait_accept(0, "soma");
    wait_idle("soma");

    // Backpressure: req1 equality held unconsumed while req0 waits.
    bus.resp1_pronto = 1'b0;
    present(1, 4'd11, 32'hDEAD, 32'hDEAD);
    wait_accept(1, "igualdade");
    present(0, 4'd0, 32'd1, 32'd2);
    repeat (ESPERA + 5) tick();
    bus.resp1_pronto = 1'b1;
    wait_accept(0, "apos_backpressure");
    wait_idle("backpressure");

    present(0, 4'd2, 32'd6, 32'd7);
    wait_accept(0, "mult");
    wait_idle("mult");

    present(0, 4'd3, 32'd100, 32'd0);
    wait_accept(0, "div_zero");
    wait_idle("div_zero");
    present(1, 4'd4, 32'd55, 32'd0);
    wait_accept(1, "rem_zero");
    wait_idle("rem_zero");

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      acc0 = bus.req0_valido && bus.req0_pronto;
      acc1 = bus.req1_valido && bus.req1_pronto;
      tick();
      if (acc0 || (bus.req0_valido && $urandom_range(0, 7) == 0)) withdraw(0);
      if (acc1 || (bus.req1_valido && $urandom_range(0, 7) == 0)) withdraw(1);
      if (!bus.req0_valido && $urandom_range(0, 2) == 0) rand_present(0);
      if (!bus.req1_valido && $urandom_range(0, 2) == 0) rand_present(1);
      bus.resp0_pronto = ($urandom_range(0, 3) != 0);
      bus.resp1_pronto = ($urandom_range(0, 3) != 0);
    end
    withdraw(0); withdraw(1);
    bus.resp0_pronto = 1'b1; bus.resp1_pronto = 1'b1;
    wait_idle("aleatorio");

    // Reset one cycle into an operation: dropped, then a tie goes to requester 0.
    present(1, 4'd0, 32'd1, 32'd1);
    wait_accept(1, "antes_reset");
    wait_idle("antes_reset");
    present(0, 4'd2, 32'd3, 32'd4);
    wait_accept(0, "reset_meio");
    tick();
    reset = 1'b1;
    present(0, 4'd7, 32'h0F0F, 32'h00FF);
    present(1, 4'd6, 32'h1000, 32'h0001);
    repeat (2) tick();
    reset = 1'b0;
    first = 1'b1; t = 0; grants = 0;
    while (grants == 0 && t < 64) begin
      @(negedge clock);
      if (bus.req0_valido && bus.req0_pronto) begin first = 1'b0; grants++; end
      if (bus.req1_valido && bus.req1_pronto) begin first = 1'b1; grants++; end
      tick();
      t++;
    end
    withdraw(0); withdraw(1);
    chk("empate_pos_reset", {63'd0, first}, 64'd0);
    wait_idle("pos_reset");

    repeat (3) tick();
    chk("fila_final", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
